// File: rtl/dual_port_sram_sync_if.sv
// Bus bundle for the dual-port data memory: one symmetric request/response group per port
// plus the shared ready/collision status lines.
interface dual_port_sram_sync_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
);
   logic              ce_r;
   logic              rw_r;
   logic              oe_r;
   logic [ADDR_W-1:0] address_r;
   logic [DATA_W-1:0] wdata_r;
   logic [DATA_W-1:0] rdata_r;
   logic              rvalid_r;
   logic              err_r;

   logic              ce_l;
   logic              rw_l;
   logic              oe_l;
   logic [ADDR_W-1:0] address_l;
   logic [DATA_W-1:0] wdata_l;
   logic [DATA_W-1:0] rdata_l;
   logic              rvalid_l;
   logic              err_l;

   logic              ready;
   logic              collision;

   modport master (
      output ce_r, rw_r, oe_r, address_r, wdata_r,
      output ce_l, rw_l, oe_l, address_l, wdata_l,
      input  rdata_r, rvalid_r, err_r,
      input  rdata_l, rvalid_l, err_l,
      input  ready, collision
   );

   modport slave (
      input  ce_r, rw_r, oe_r, address_r, wdata_r,
      input  ce_l, rw_l, oe_l, address_l, wdata_l,
      output rdata_r, rvalid_r, err_r,
      output rdata_l, rvalid_l, err_l,
      output ready, collision
   );
endinterface

// File: rtl/dual_port_sram_sync.sv
// Synchronous true dual-port SRAM with a power-up clear sweep, same-address write arbitration,
// selectable read-during-write behaviour and out-of-range address detection.
module dual_port_sram_sync #(
   parameter int                DATA_W    = 8,
   parameter int                ADDR_W    = 10,
   parameter int                DEPTH     = 1024,
   parameter int                PRIORITY  = 0,
   parameter int                RDW_MODE  = 1,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input logic                  clk,
   input logic                  rst,
   dual_port_sram_sync_if.slave bus
);

   localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic {
      CLEAR,
      READY
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [IDX_W-1:0]  clr_cnt_q;
   logic [IDX_W-1:0]  clr_cnt_d;
   logic              clear_we;
   logic              ready;

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   logic              acc_r, acc_l;
   logic              in_r, in_l;
   logic [IDX_W-1:0]  idx_r, idx_l;
   logic              wr_req_r, wr_req_l;
   logic              rd_r, rd_l;
   logic              same_addr;
   logic              both_wr_same;
   logic              we_r, we_l;
   logic [DATA_W-1:0] rd_data_r, rd_data_l;

   logic [DATA_W-1:0] rdata_q_r, rdata_q_l;
   logic              rvalid_q_r, rvalid_q_l;
   logic              err_q_r, err_q_l;
   logic              collision_q;

   // Sweep state and clear pointer; reset at any time restarts the sweep from word 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      clear_we  = 1'b0;
      case (state_q)
         CLEAR: begin
            clear_we  = 1'b1;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_IDX) begin
               state_d   = READY;
               clr_cnt_d = '0;
            end
         end
         READY: begin
            state_d = READY;
         end
         default: begin
            state_d = CLEAR;
         end
      endcase
   end

   assign ready = (state_q == READY);

   // Request decode: the range test is done at full address width so aliasing words are never touched.
   assign acc_r    = ready & ~bus.ce_r;
   assign acc_l    = ready & ~bus.ce_l;
   assign in_r     = {1'b0, bus.address_r} < DEPTH_V;
   assign in_l     = {1'b0, bus.address_l} < DEPTH_V;
   assign idx_r    = bus.address_r[IDX_W-1:0];
   assign idx_l    = bus.address_l[IDX_W-1:0];
   assign wr_req_r = acc_r & ~bus.rw_r & in_r;
   assign wr_req_l = acc_l & ~bus.rw_l & in_l;
   assign rd_r     = acc_r & bus.rw_r;
   assign rd_l     = acc_l & bus.rw_l;

   assign same_addr    = (bus.address_r == bus.address_l);
   assign both_wr_same = wr_req_r & wr_req_l & same_addr;
   assign we_r         = wr_req_r & ~(both_wr_same & (PRIORITY == 1));
   assign we_l         = wr_req_l & ~(both_wr_same & (PRIORITY == 0));

   // Read data source: zero when out of range, optional bypass of the other port's write, else the array.
   always_comb begin
      rd_data_r = '0;
      if (in_r) begin
         if ((RDW_MODE == 1) && we_l && same_addr) begin
            rd_data_r = bus.wdata_l;
         end else begin
            rd_data_r = mem[idx_r];
         end
      end
   end

   always_comb begin
      rd_data_l = '0;
      if (in_l) begin
         if ((RDW_MODE == 1) && we_r && same_addr) begin
            rd_data_l = bus.wdata_r;
         end else begin
            rd_data_l = mem[idx_l];
         end
      end
   end

   // The array itself has no reset; its contents come only from the sweep and accepted writes.
   always_ff @(posedge clk) begin
      if (clear_we) begin
         mem[clr_cnt_q] <= CLEAR_VAL;
      end else begin
         if (we_r) begin
            mem[idx_r] <= bus.wdata_r;
         end
         if (we_l) begin
            mem[idx_l] <= bus.wdata_l;
         end
      end
   end

   // Registered read data holds until the next accepted read; status flags are single-cycle pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q_r   <= '0;
         rdata_q_l   <= '0;
         rvalid_q_r  <= 1'b0;
         rvalid_q_l  <= 1'b0;
         err_q_r     <= 1'b0;
         err_q_l     <= 1'b0;
         collision_q <= 1'b0;
      end else begin
         if (rd_r) begin
            rdata_q_r <= rd_data_r;
         end
         if (rd_l) begin
            rdata_q_l <= rd_data_l;
         end
         rvalid_q_r  <= rd_r;
         rvalid_q_l  <= rd_l;
         err_q_r     <= acc_r & ~in_r;
         err_q_l     <= acc_l & ~in_l;
         collision_q <= both_wr_same;
      end
   end

   assign bus.rdata_r   = bus.oe_r ? rdata_q_r : '0;
   assign bus.rdata_l   = bus.oe_l ? rdata_q_l : '0;
   assign bus.rvalid_r  = rvalid_q_r;
   assign bus.rvalid_l  = rvalid_q_l;
   assign bus.err_r     = err_q_r;
   assign bus.err_l     = err_q_l;
   assign bus.collision = collision_q;
   assign bus.ready     = ready;

endmodule
